// File: rtl/ddr_arb_pkg.sv
// Shared constants and route-entry type for the DDR read-command arbiter.
// Optional perf counters are enabled with DDR_RD_ARB_PERF_CNT_EN.
package ddr_arb_pkg;

  localparam int REQ_WEIGHTS = 0;
  localparam int REQ_IFMAP   = 1;
  localparam int REQ_BIAS    = 2;

  localparam int DEF_NUM_REQ     = 3;
  localparam int DEF_ADR_W       = 32;
  localparam int DEF_LEN_W       = 16;
  localparam int DEF_ROUTE_DEPTH = 4;
  localparam int DEF_ID_W        = $clog2(DEF_NUM_REQ);

  // Default-width route entry; the top re-derives it for its own parameters.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_LEN_W-1:0] length;
  } route_ent_t;

endpackage

// File: rtl/ddr_route_fifo.sv
// In-order FIFO of granted bursts; the head tells the router who owns the next beat.
module ddr_route_fifo
  import ddr_arb_pkg::*;
#(
  parameter type ent_t = route_ent_t,
  parameter int  DEPTH = DEF_ROUTE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  ent_t                       din_i,
  input  logic                       pop_i,
  output ent_t                       dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ddr_rd_cmd_arbiter.sv
// Round-robin arbiter sharing the MIG read-command port, plus in-order beat router.
// Define DDR_RD_ARB_PERF_CNT_EN to build per-requester grant/wait counters.
module ddr_rd_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADR_W       = DEF_ADR_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int ROUTE_DEPTH = DEF_ROUTE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ADR_W-1:0] req_base_adr,
  input  logic [NUM_REQ*LEN_W-1:0] req_length,
  output logic [NUM_REQ-1:0]       req_grant,
  input  logic                     ddr_cmd_ready,
  output logic                     ddr_cmd_valid,
  output logic [ADR_W-1:0]         ddr_cmd_base_adr,
  output logic [LEN_W-1:0]         ddr_cmd_length,
  input  logic                     ddr_rd_data_valid,
  output logic [NUM_REQ-1:0]       rd_beat_valid,
  output logic [NUM_REQ-1:0]       rd_burst_last,
  output logic                     busy,
  output logic                     err_orphan_beat,
  output logic [NUM_REQ*32-1:0]    perf_grant_cnt,
  output logic [NUM_REQ*32-1:0]    perf_wait_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(ROUTE_DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [LEN_W-1:0] length;
  } rent_t;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, win_id;
  logic               win_vld;
  logic [NUM_REQ-1:0] elig;
  logic [LEN_W-1:0]   win_len;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               orphan_q, orphan_d;
  logic               fifo_full, fifo_empty, push, pop, beat_hit;
  logic [CW-1:0]      fifo_cnt;
  rent_t              push_ent, head;

  // Full is judged on the registered count, so a same-cycle pop cannot free a slot.
  assign elig = req_valid & {NUM_REQ{ddr_cmd_ready && !fifo_full}};

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign win_len = req_length[int'(win_id)*LEN_W +: LEN_W];

  always_comb begin
    req_grant = '0;
    if (win_vld) req_grant[win_id] = 1'b1;
  end

  // A zero-length command is accepted from the requester but never reaches the MIG.
  assign ddr_cmd_valid    = win_vld && (win_len != '0);
  assign ddr_cmd_base_adr = win_vld ? req_base_adr[int'(win_id)*ADR_W +: ADR_W] : '0;
  assign ddr_cmd_length   = win_vld ? win_len : '0;
  assign push             = ddr_cmd_valid;
  assign push_ent         = '{id: win_id, length: win_len};
  assign rr_ptr_d         = win_vld ? win_id : rr_ptr_q;

  ddr_route_fifo #(
    .ent_t (rent_t),
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign beat_hit = ddr_rd_data_valid && !fifo_empty;
  assign pop      = beat_hit && (beat_cnt_q == head.length);
  assign busy     = (fifo_cnt != '0);

  always_comb begin
    rd_beat_valid = '0;
    rd_burst_last = '0;
    if (beat_hit) rd_beat_valid[head.id] = 1'b1;
    if (pop)      rd_burst_last[head.id] = 1'b1;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop)           beat_cnt_d = LEN_W'(1);
    else if (beat_hit) beat_cnt_d = beat_cnt_q + LEN_W'(1);
  end

  assign orphan_d        = orphan_q || (ddr_rd_data_valid && fifo_empty);
  assign err_orphan_beat = orphan_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      beat_cnt_q <= LEN_W'(1);
      orphan_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      orphan_q   <= orphan_d;
    end
  end

`ifdef DDR_RD_ARB_PERF_CNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [31:0] gcnt_q, wcnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        gcnt_q <= '0;
        wcnt_q <= '0;
      end else begin
        if (req_grant[i] && (gcnt_q != '1))                 gcnt_q <= gcnt_q + 32'd1;
        if (req_valid[i] && !req_grant[i] && (wcnt_q != '1)) wcnt_q <= wcnt_q + 32'd1;
      end
    end
    assign perf_grant_cnt[i*32 +: 32] = gcnt_q;
    assign perf_wait_cnt[i*32 +: 32]  = wcnt_q;
  end
`else
  assign perf_grant_cnt = '0;
  assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_ddr_rd_cmd_arbiter.sv
// Directed bench for ddr_rd_cmd_arbiter: grant order, stalls, routing, orphans, reset.
module tb_ddr_rd_cmd_arbiter;

  localparam int N = 3, AW = 32, LW = 16;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_base_adr = '0;
  logic [N*LW-1:0] req_length = '0;
  logic [N-1:0]    req_grant, rd_beat_valid, rd_burst_last;
  logic            ddr_cmd_ready = 1'b0, ddr_cmd_valid, ddr_rd_data_valid = 1'b0;
  logic [AW-1:0]   ddr_cmd_base_adr;
  logic [LW-1:0]   ddr_cmd_length;
  logic            busy, err_orphan_beat;
  logic [N*32-1:0] perf_grant_cnt, perf_wait_cnt;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ddr_rd_cmd_arbiter #(.NUM_REQ(N), .ADR_W(AW), .LEN_W(LW), .ROUTE_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_base_adr      (req_base_adr),
    .req_length        (req_length),
    .req_grant         (req_grant),
    .ddr_cmd_ready     (ddr_cmd_ready),
    .ddr_cmd_valid     (ddr_cmd_valid),
    .ddr_cmd_base_adr  (ddr_cmd_base_adr),
    .ddr_cmd_length    (ddr_cmd_length),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .rd_beat_valid     (rd_beat_valid),
    .rd_burst_last     (rd_burst_last),
    .busy              (busy),
    .err_orphan_beat   (err_orphan_beat),
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_wait_cnt     (perf_wait_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] adr, input logic [LW-1:0] len);
    req_base_adr[i*AW +: AW] = adr;
    req_length[i*LW +: LW]   = len;
  endtask

  // Drives len consecutive beats and checks they land on requester id.
  task automatic beats(input int id, input int len);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      ddr_rd_data_valid = 1'b1;
      #1;
      chk("beat_valid", 64'(rd_beat_valid), 64'(1 << id));
      chk("burst_last", 64'(rd_burst_last), (k == len) ? 64'(1 << id) : 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    ddr_rd_data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef DDR_RD_ARB_PERF_CNT_EN
  int exp_pg [N];
  int exp_pw [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        exp_pg[i] = 0;
        exp_pw[i] = 0;
      end else begin
        if (req_grant[i]) exp_pg[i]++;
        if (req_valid[i] && !req_grant[i]) exp_pw[i]++;
      end
    end
  end
`endif

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_grant", 64'(req_grant), 0);
    chk("rst_cmd_valid", 64'(ddr_cmd_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_orphan", 64'(err_orphan_beat), 0);
    chk("rst_beat", 64'(rd_beat_valid), 0);

    // Single requester, 32-beat burst
    @(negedge clk);
    ddr_cmd_ready = 1'b1;
    set_req(0, 32'h1000, 16'd32);
    req_valid = 3'b001;
    #1;
    chk("s_grant", 64'(req_grant), 64'b001);
    chk("s_cmd_valid", 64'(ddr_cmd_valid), 1);
    chk("s_cmd_adr", 64'(ddr_cmd_base_adr), 64'h1000);
    chk("s_cmd_len", 64'(ddr_cmd_length), 32);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("s_busy", 64'(busy), 1);
    beats(0, 32);
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("s_idle", 64'(busy), 0);

    // Round-robin 0,1,2,0 then full-FIFO stall
    do_reset();
    set_req(0, 32'h2000, 16'd4);
    set_req(1, 32'h3000, 16'd8);
    set_req(2, 32'h4000, 16'd2);
    req_valid = 3'b111;
    #1;
    chk("rr_g0", 64'(req_grant), 64'b001);
    chk("rr_len0", 64'(ddr_cmd_length), 4);
    @(negedge clk); #1;
    chk("rr_g1", 64'(req_grant), 64'b010);
    chk("rr_adr1", 64'(ddr_cmd_base_adr), 64'h3000);
    @(negedge clk); #1;
    chk("rr_g2", 64'(req_grant), 64'b100);
    @(negedge clk); #1;
    chk("rr_g3", 64'(req_grant), 64'b001);
    @(negedge clk); #1;
    chk("full_grant", 64'(req_grant), 0);
    chk("full_cmd_valid", 64'(ddr_cmd_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ddr_rd_data_valid = 1'b1;
      #1;
      chk("full_beat", 64'(rd_beat_valid), 64'b001);
      chk("full_last", 64'(rd_burst_last), (k == 4) ? 64'b001 : 64'd0);
      chk("full_nogrant", 64'(req_grant), 0);
    end
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("refill_grant", 64'(req_grant), 64'b010);
    chk("refill_len", 64'(ddr_cmd_length), 8);
    @(negedge clk);
    req_valid = '0;
    beats(1, 8);
    beats(2, 2);
    beats(0, 4);
    beats(1, 8);
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("rr_idle", 64'(busy), 0);

    // Command port not ready
    set_req(1, 32'h5000, 16'd3);
    ddr_cmd_ready = 1'b0;
    req_valid = 3'b010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("nr_grant", 64'(req_grant), 0);
      chk("nr_cmd_valid", 64'(ddr_cmd_valid), 0);
      @(negedge clk);
    end
    ddr_cmd_ready = 1'b1;
    #1;
    chk("nr_grant_go", 64'(req_grant), 64'b010);
    chk("nr_cmd_go", 64'(ddr_cmd_valid), 1);
    @(negedge clk);
    req_valid = '0;
    beats(1, 3);
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("nr_idle", 64'(busy), 0);

    // Orphan beat
    @(negedge clk);
    ddr_rd_data_valid = 1'b1;
    #1;
    chk("orph_beat", 64'(rd_beat_valid), 0);
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("orph_err", 64'(err_orphan_beat), 1);

    // Zero-length command, then pointer advance check
    @(negedge clk);
    set_req(2, 32'h6000, 16'd0);
    req_valid = 3'b100;
    #1;
    chk("z_grant", 64'(req_grant), 64'b100);
    chk("z_cmd_valid", 64'(ddr_cmd_valid), 0);
    @(negedge clk);
    set_req(0, 32'h7000, 16'd5);
    set_req(2, 32'h8000, 16'd3);
    req_valid = 3'b101;
    #1;
    chk("z_busy", 64'(busy), 0);
    chk("z_rr_adv", 64'(req_grant), 64'b001);
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    chk("z_g2", 64'(req_grant), 64'b100);
    chk("z_adr2", 64'(ddr_cmd_base_adr), 64'h8000);

    // Reset with two bursts outstanding
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("pre_rst_busy", 64'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_orphan_clr", 64'(err_orphan_beat), 0);
    @(negedge clk);
    ddr_rd_data_valid = 1'b1;
    #1;
    chk("mr_beat", 64'(rd_beat_valid), 0);
    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    #1;
    chk("mr_orphan", 64'(err_orphan_beat), 1);

`ifdef DDR_RD_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      chk("perf_grant", 64'(perf_grant_cnt[i*32 +: 32]), 64'(exp_pg[i]));
      chk("perf_wait", 64'(perf_wait_cnt[i*32 +: 32]), 64'(exp_pw[i]));
    end
`else
    chk("perf_grant_tied", 64'(perf_grant_cnt), 0);
    chk("perf_wait_tied", 64'(perf_wait_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
